// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic          stop_q, stop_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (tx_valid_i) begin
                    shift_d = tx_data_i;
                    par_d   = (PARITY == 1) ? ~^tx_data_i : ^tx_data_i;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                        idx_d   = 3'd0;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so tx_o stays a clean flop output.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[idx_d];
            S_PAR:   tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= 3'd0;
            stop_q  <= 1'b0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = (state_q == S_IDLE);
    assign tx_busy_o  = (state_q != S_IDLE);
    assign tx_done_o  = (state_q == S_STOP) && bit_end && (stop_q == STOP_LAST);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a frame-level reference model
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [4];
    logic       valid [4];
    logic [7:0] data  [4];
    logic       ready [4];
    logic       txl   [4];
    logic       busy  [4];
    logic       done  [4];

    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk_i(clk), .rst_i(rst[0]), .tx_data_i(data[0]), .tx_valid_i(valid[0]),
        .tx_ready_o(ready[0]), .tx_o(txl[0]), .tx_busy_o(busy[0]), .tx_done_o(done[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk_i(clk), .rst_i(rst[1]), .tx_data_i(data[1]), .tx_valid_i(valid[1]),
        .tx_ready_o(ready[1]), .tx_o(txl[1]), .tx_busy_o(busy[1]), .tx_done_o(done[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk_i(clk), .rst_i(rst[2]), .tx_data_i(data[2]), .tx_valid_i(valid[2]),
        .tx_ready_o(ready[2]), .tx_o(txl[2]), .tx_busy_o(busy[2]), .tx_done_o(done[2]));
    uart_tx #(.CLKS_PER_BIT(868), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk_i(clk), .rst_i(rst[3]), .tx_data_i(data[3]), .tx_valid_i(valid[3]),
        .tx_ready_o(ready[3]), .tx_o(txl[3]), .tx_busy_o(busy[3]), .tx_done_o(done[3]));

    int cpb     [4] = '{4, 4, 4, 868};
    int par_cfg [4] = '{0, 1, 2, 0};
    int stp_cfg [4] = '{1, 1, 1, 2};

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          chk_en = 1'b0;
    int          rem      [4] = '{0, 0, 0, 0};
    int          nb       [4] = '{0, 0, 0, 0};
    int          hs_cnt   [4] = '{0, 0, 0, 0};
    int          hs_cyc   [4] = '{0, 0, 0, 0};
    int          done_cnt [4] = '{0, 0, 0, 0};
    logic [11:0] fr [4];
    logic [7:0]  exp_q [$];
    int          rx_ok = 0;

    localparam int NRAND0 = 20;

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, act, exp);
        end
    endtask

    // Reference model: a frame is a list of line levels, each held cpb cycles,
    // counted down from the handshake edge; the block is ready only when nothing remains.
    initial forever begin
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 4; d++) begin
            if (rst[d] === 1'b1) begin
                rem[d] = 0;
                if (d == 0) exp_q.delete();
            end else if (rem[d] > 0) begin
                rem[d]--;
            end else if (valid[d] === 1'b1) begin
                fr[d]    = '1;
                fr[d][0] = 1'b0;
                for (int i = 0; i < 8; i++) fr[d][1+i] = data[d][i];
                if (par_cfg[d] == 1) fr[d][9] = ($countones(data[d]) % 2 == 0);
                if (par_cfg[d] == 2) fr[d][9] = ($countones(data[d]) % 2 == 1);
                nb[d]     = 9 + ((par_cfg[d] != 0) ? 1 : 0) + stp_cfg[d];
                rem[d]    = nb[d] * cpb[d];
                hs_cnt[d] = hs_cnt[d] + 1;
                hs_cyc[d] = cyc;
                if (d == 0) exp_q.push_back(data[d]);
            end
        end
    end

    initial begin : cmp
        logic etx;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 4; d++) begin
                    etx = 1'b1;
                    if (rem[d] > 0) etx = fr[d][(nb[d] * cpb[d] - rem[d]) / cpb[d]];
                    check("tx",    d, 32'(txl[d]),   32'(etx));
                    check("ready", d, 32'(ready[d]), 32'(rem[d] == 0));
                    check("busy",  d, 32'(busy[d]),  32'(rem[d] > 0));
                    check("done",  d, 32'(done[d]),  32'(rem[d] == 1));
                    if (done[d] === 1'b1) done_cnt[d]++;
                end
            end
        end
    end

    // Mid-bit sampling receiver on dut0 (4 clocks per bit, no parity).
    initial begin : rx
        bit         rx_act;
        int         rx_cnt;
        logic [7:0] rx_b;
        rx_act = 1'b0;
        rx_cnt = 0;
        rx_b   = 8'd0;
        forever begin
            @(negedge clk);
            if (rst[0] === 1'b1) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (chk_en && txl[0] === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt - 2) % 4 == 0)
                    rx_b[(rx_cnt - 6) / 4] = txl[0];
                if (rx_cnt == 38) begin
                    check("rx_stop", 0, 32'(txl[0]), 32'd1);
                    check("rx_pending", 0, 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) check("rx_byte", 0, 32'(rx_b), 32'(exp_q.pop_front()));
                    rx_ok++;
                    rx_act = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] b);
        int prev = hs_cnt[d];
        int n    = 0;
        data[d]  = b;
        valid[d] = 1'b1;
        while (hs_cnt[d] == prev && n < 20000) begin
            tick();
            n++;
        end
        valid[d] = 1'b0;
        check("hs_timeout", d, 32'(hs_cnt[d] - prev), 32'd1);
    endtask

    task automatic wait_done(input int d, output int dc);
        dc = -1;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (done[d] === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        check("done_seen", d, 32'(dc >= 0), 32'd1);
    endtask

    task automatic seq0();
        int dc, rc, prev, dprev, last, n;
        send(0, 8'h55);
        wait_done(0, dc);
        check("done_lat", 0, 32'(dc - hs_cyc[0] + 1), 32'd40);
        rc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready[0] === 1'b1) begin
                rc = cyc;
                break;
            end
        end
        check("ready_lat", 0, 32'(rc - hs_cyc[0] + 1), 32'd41);
        tick();

        dprev    = done_cnt[0];
        last     = 0;
        data[0]  = 8'h0A;
        valid[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            prev = hs_cnt[0];
            n    = 0;
            while (hs_cnt[0] == prev && n < 200) begin
                tick();
                n++;
            end
            check("b2b_hs", 0, 32'(hs_cnt[0] - prev), 32'd1);
            if (i > 0) check("b2b_period", 0, 32'(hs_cyc[0] - last), 32'd41);
            last    = hs_cyc[0];
            data[0] = 8'(i + 11);
        end
        valid[0] = 1'b0;
        wait_done(0, dc);
        tick();
        check("b2b_dones", 0, 32'(done_cnt[0] - dprev), 32'd100);

        send(0, 8'h3C);
        prev = hs_cnt[0];
        for (int j = 0; j < 30; j++) begin
            tick();
            data[0]  = 8'($urandom);
            valid[0] = 1'($urandom % 2);
        end
        valid[0] = 1'b0;
        wait_done(0, dc);
        repeat (5) tick();
        check("no_second", 0, 32'(hs_cnt[0] - prev), 32'd0);

        send(0, 8'hFF);
        dprev = done_cnt[0];
        repeat (14) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("rst_tx",    0, 32'(txl[0]),   32'd1);
        check("rst_ready", 0, 32'(ready[0]), 32'd1);
        check("rst_busy",  0, 32'(busy[0]),  32'd0);
        repeat (50) tick();
        check("rst_nodone", 0, 32'(done_cnt[0] - dprev), 32'd0);

        send(0, 8'h81);
        for (int r = 0; r < NRAND0; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(0, 8'($urandom));
        end
        wait_done(0, dc);
        tick();
    endtask

    task automatic seq_par(input int d, input logic pb);
        int dc;
        send(d, 8'hA5);
        repeat (39) @(negedge clk);
        check("par_bit", d, 32'(txl[d]), 32'(pb));
        wait_done(d, dc);
        check("par_len", d, 32'(dc - hs_cyc[d] + 1), 32'd44);
        tick();
        for (int r = 0; r < 15; r++) begin
            repeat ($urandom_range(0, 5)) tick();
            send(d, 8'($urandom));
        end
        wait_done(d, dc);
        tick();
    endtask

    task automatic seq_long();
        int low  = 0;
        int high = 0;
        send(3, 8'h00);
        @(negedge clk);
        while (txl[3] === 1'b0 && low < 20000) begin
            low++;
            @(negedge clk);
        end
        while (done[3] !== 1'b1 && high < 20000) begin
            high++;
            @(negedge clk);
        end
        high++;
        check("long_low",  3, 32'(low),  32'd7812);
        check("long_high", 3, 32'(high), 32'd1736);
        tick();
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            rst[d]   = 1'b1;
            valid[d] = 1'b0;
            data[d]  = 8'd0;
        end
        repeat (3) tick();
        chk_en = 1'b1;
        for (int d = 0; d < 4; d++) rst[d] = 1'b0;
        repeat (20) tick();
        check("idle_tx",    0, 32'(txl[0]),   32'd1);
        check("idle_ready", 0, 32'(ready[0]), 32'd1);
        check("idle_busy",  0, 32'(busy[0]),  32'd0);

        fork
            seq0();
            seq_par(1, 1'b1);
            seq_par(2, 1'b0);
            seq_long();
        join

        repeat (10) tick();
        check("rx_count", 0, 32'(rx_ok), 32'(1 + 100 + 1 + 1 + NRAND0));
        check("rx_left",  0, 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

endmodule
